// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bundle for pipe_stage_reg: upstream entry, stall/flush controls
// and the registered downstream entry.
interface pipe_stage_reg_if #(
  parameter int DATA_W    = 149,
  parameter int CTRL_W    = 16,
  parameter int CTRL_DROP = 1,
  parameter int PC_W      = 32
);
  logic                          in_valid;
  logic [DATA_W-1:0]             in_data;
  logic [CTRL_W+CTRL_DROP-1:0]   in_ctrl;
  logic [PC_W-1:0]               in_pc;
  logic                          stall;
  logic                          flush;
  logic                          out_valid;
  logic [DATA_W-1:0]             out_data;
  logic [CTRL_W-1:0]             out_ctrl;
  logic [PC_W-1:0]               out_pc;

  // Upstream/hazard logic side.
  modport master (
    output in_valid, in_data, in_ctrl, in_pc, stall, flush,
    input  out_valid, out_data, out_ctrl, out_pc
  );

  // The stage register itself.
  modport slave (
    input  in_valid, in_data, in_ctrl, in_pc, stall, flush,
    output out_valid, out_data, out_ctrl, out_pc
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// ID/EX-class pipeline stage register with stall/flush, valid-gated control,
// saturating stall/flush performance counters and a sticky stall watchdog.
module pipe_stage_reg #(
  parameter int DATA_W      = 149,
  parameter int CTRL_W      = 16,
  parameter int CTRL_DROP   = 1,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stage_reg_if.slave    bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic               stall_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [PC_W-1:0]   pc_q;
  logic [CTRL_W-1:0] ctrl_kept;
  logic [CNT_W-1:0]  run_len;
  logic [CNT_W-1:0]  run_next;
  logic              stall_edge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Low-order control bits were already consumed by the receiving stage.
  assign ctrl_kept  = bus.in_ctrl[CTRL_W+CTRL_DROP-1:CTRL_DROP];
  assign stall_edge = bus.stall && !bus.flush;

  always_comb begin
    run_next = '0;
    if (stall_edge) run_next = sat_inc(run_len);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      pc_q    <= '0;
    end else if (bus.flush) begin
      // Bubble keeps data/PC of the killed entry for debug visibility.
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= bus.in_data;
      pc_q    <= bus.in_pc;
    end else if (!bus.stall) begin
      valid_q <= bus.in_valid;
      data_q  <= bus.in_data;
      pc_q    <= bus.in_pc;
      ctrl_q  <= bus.in_valid ? ctrl_kept : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      run_len   <= '0;
      stall_err <= 1'b0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      run_len   <= '0;
      stall_err <= 1'b0;
    end else begin
      if (stall_edge && valid_q)          stall_cnt <= sat_inc(stall_cnt);
      if (bus.flush && bus.in_valid)      flush_cnt <= sat_inc(flush_cnt);
      run_len <= run_next;
      if (run_next == LIMIT)              stall_err <= 1'b1;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ctrl  = ctrl_q;
  assign bus.out_pc    = pc_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (wide counters with a short
// watchdog, and 2-bit saturating counters) share stimulus and a reference model.
module tb_pipe_stage_reg;

  localparam int DATA_W = 149;
  localparam int CTRL_W = 16;
  localparam int DROP   = 1;
  localparam int PC_W   = 32;

  logic clk = 1'b0;
  logic reset;
  logic cnt_clr;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_DROP(DROP), .PC_W(PC_W)) bus_a ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_DROP(DROP), .PC_W(PC_W)) bus_b ();

  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [1:0]  stall_cnt_b, flush_cnt_b;
  logic        stall_err_a, stall_err_b;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_DROP(DROP), .PC_W(PC_W),
                   .CNT_W(16), .STALL_LIMIT(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .stall_err(stall_err_a));

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_DROP(DROP), .PC_W(PC_W),
                   .CNT_W(2), .STALL_LIMIT(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .stall_err(stall_err_b));

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic [PC_W-1:0]   pc;
    int                sc_a, fc_a, sc_b, fc_b;
    bit                err_a, err_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: index 0 is dut_a, index 1 is dut_b.
  int                LIMIT[2] = '{4, 3};
  int                MAXC[2]  = '{65535, 3};
  logic              m_v;
  logic [DATA_W-1:0] m_d;
  logic [CTRL_W-1:0] m_c;
  logic [PC_W-1:0]   m_pc;
  int                m_sc[2], m_fc[2], m_run[2];
  bit                m_err[2];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_d = '0; m_c = '0; m_pc = '0;
    for (int i = 0; i < 2; i++) begin
      m_sc[i] = 0; m_fc[i] = 0; m_run[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  // Applies one clock edge's worth of architectural rules to the model.
  task automatic model_edge(input bit v, input logic [DATA_W-1:0] d, input logic [16:0] c,
                            input logic [PC_W-1:0] p, input bit st, input bit fl, input bit clr);
    bit   held_valid;
    exp_t e;
    held_valid = m_v;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_sc[i] = 0; m_fc[i] = 0; m_run[i] = 0; m_err[i] = 1'b0;
      end else begin
        if (st && !fl && held_valid && m_sc[i] < MAXC[i]) m_sc[i] = m_sc[i] + 1;
        if (fl && v && m_fc[i] < MAXC[i]) m_fc[i] = m_fc[i] + 1;
        if (st && !fl) m_run[i] = (m_run[i] < MAXC[i]) ? m_run[i] + 1 : m_run[i];
        else           m_run[i] = 0;
        if (m_run[i] == LIMIT[i]) m_err[i] = 1'b1;
      end
    end
    if (fl) begin
      m_v = 1'b0; m_c = '0; m_d = d; m_pc = p;
    end else if (!st) begin
      m_v = v; m_d = d; m_pc = p;
      m_c = v ? 16'(c >> DROP) : 16'h0;
    end
    e.v = m_v; e.d = m_d; e.c = m_c; e.pc = m_pc;
    e.sc_a = m_sc[0]; e.fc_a = m_fc[0]; e.err_a = m_err[0];
    e.sc_b = m_sc[1]; e.fc_b = m_fc[1]; e.err_b = m_err[1];
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [16:0] c,
                       input logic [PC_W-1:0] p, input bit st, input bit fl, input bit clr);
    bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_ctrl = c; bus_a.in_pc = p;
    bus_a.stall = st;   bus_a.flush = fl;
    bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_ctrl = c; bus_b.in_pc = p;
    bus_b.stall = st;   bus_b.flush = fl;
    cnt_clr = clr;
  endtask

  task automatic step(input bit v, input logic [DATA_W-1:0] d, input logic [16:0] c,
                      input logic [PC_W-1:0] p, input bit st, input bit fl, input bit clr);
    @(negedge clk);
    #1;
    drive(v, d, c, p, st, fl, clr);
    @(posedge clk);
    model_edge(v, d, c, p, st, fl, clr);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_a"}, 160'(bus_a.out_valid), 160'(0));
    check({tag, "_data_a"},  160'(bus_a.out_data),  160'(0));
    check({tag, "_ctrl_a"},  160'(bus_a.out_ctrl),  160'(0));
    check({tag, "_pc_a"},    160'(bus_a.out_pc),    160'(0));
    check({tag, "_scnt_a"},  160'(stall_cnt_a),     160'(0));
    check({tag, "_fcnt_a"},  160'(flush_cnt_a),     160'(0));
    check({tag, "_err_a"},   160'(stall_err_a),     160'(0));
    check({tag, "_valid_b"}, 160'(bus_b.out_valid), 160'(0));
    check({tag, "_pc_b"},    160'(bus_b.out_pc),    160'(0));
    check({tag, "_scnt_b"},  160'(stall_cnt_b),     160'(0));
    check({tag, "_err_b"},   160'(stall_err_b),     160'(0));
  endtask

  // Monitor: every cycle the stage presents a new registered entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_valid_a", 160'(bus_a.out_valid), 160'(e.v));
        check("out_data_a",  160'(bus_a.out_data),  160'(e.d));
        check("out_ctrl_a",  160'(bus_a.out_ctrl),  160'(e.c));
        check("out_pc_a",    160'(bus_a.out_pc),    160'(e.pc));
        check("stall_cnt_a", 160'(stall_cnt_a),     160'(e.sc_a));
        check("flush_cnt_a", 160'(flush_cnt_a),     160'(e.fc_a));
        check("stall_err_a", 160'(stall_err_a),     160'(e.err_a));
        check("out_valid_b", 160'(bus_b.out_valid), 160'(e.v));
        check("out_ctrl_b",  160'(bus_b.out_ctrl),  160'(e.c));
        check("out_pc_b",    160'(bus_b.out_pc),    160'(e.pc));
        check("stall_cnt_b", 160'(stall_cnt_b),     160'(e.sc_b));
        check("flush_cnt_b", 160'(flush_cnt_b),     160'(e.fc_b));
        check("stall_err_b", 160'(stall_err_b),     160'(e.err_b));
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all_zero("reset");
    #11 reset = 1'b1;

    // Reset then load.
    step(1'b1, 149'h5A, 17'h1_0003, 32'h0040_0004, 1'b0, 1'b0, 1'b0);

    // Stall hold: 3 stalled edges with a new PC waiting, then release.
    step(1'b1, rand_data(), 17'h0_1234, 32'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rand_data(), 17'h1_5555, 32'h14, 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_data(), 17'h1_5555, 32'h14, 1'b0, 1'b0, 1'b0);

    // Flush wins over stall.
    step(1'b1, rand_data(), 17'h1_FFFF, 32'h20, 1'b1, 1'b1, 1'b0);

    // Invalid load never carries control.
    step(1'b0, rand_data(), 17'h1_FFFF, 32'h24, 1'b0, 1'b0, 1'b0);

    // Watchdog: run of 3, release, run of 4, then clear.
    step(1'b1, rand_data(), 17'h0_00F1, 32'h28, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rand_data(), 17'h0_0002, 32'h2C, 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_data(), 17'h0_0002, 32'h2C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rand_data(), 17'h0_0004, 32'h30, 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_data(), 17'h0_0004, 32'h30, 1'b0, 1'b0, 1'b1);

    // Saturation: 5 stalled edges on a valid entry.
    step(1'b1, rand_data(), 17'h0_0006, 32'h34, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, rand_data(), 17'h0_0008, 32'h38, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rand_data(), 17'($urandom), $urandom,
           $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);

    // Asynchronous reset mid-cycle while stalling; run length restarts afterwards.
    step(1'b1, rand_data(), 17'h0_0010, 32'h40, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    #3 reset = 1'b1;
    step(1'b1, rand_data(), 17'h0_0012, 32'h44, 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_data(), 17'h0_0012, 32'h44, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rand_data(), 17'h0_0014, 32'h48, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #2 check("scoreboard_drain", 160'(exp_q.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
